// File: rtl/ex_issue_if.sv
// ============================================================================
// Module : ex_issue_if
// Brief  : Decode-side and ALU-side handshake/data bundle of the ID/EX stage.
//          The forwarding signals exist only when FWD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_issue_if #(
   parameter int XLEN    = 32,
   parameter int REGADDR = 5
);
   logic               flush;
   logic               id_valid;
   logic               id_ready;
   logic [6:0]         id_opcode;
   logic [2:0]         id_funct3;
   logic               id_funct7b5;
   logic [XLEN-1:0]    id_rs1_data;
   logic [XLEN-1:0]    id_rs2_data;
   logic [XLEN-1:0]    id_imm;
   logic [XLEN-1:0]    id_pc;
   logic [REGADDR-1:0] id_rd;
`ifdef FWD_EN
   logic [REGADDR-1:0] id_rs1;
   logic [REGADDR-1:0] id_rs2;
   logic               fwd_valid;
   logic [REGADDR-1:0] fwd_rd;
   logic [XLEN-1:0]    fwd_data;
`endif
   logic               ex_valid;
   logic               ex_ready;
   logic [XLEN-1:0]    alu_in1;
   logic [XLEN-1:0]    alu_in2;
   logic [3:0]         alu_funsel;
   logic [REGADDR-1:0] ex_rd;
   logic               ex_is_branch;
   logic               ex_is_cmp;
   logic [2:0]         ex_funct3;
   logic [XLEN-1:0]    ex_rs2_data;
   logic               ex_illegal;

   modport master (
      output flush, id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1_data,
             id_rs2_data, id_imm, id_pc, id_rd, ex_ready,
`ifdef FWD_EN
             id_rs1, id_rs2, fwd_valid, fwd_rd, fwd_data,
`endif
      input  id_ready, ex_valid, alu_in1, alu_in2, alu_funsel, ex_rd,
             ex_is_branch, ex_is_cmp, ex_funct3, ex_rs2_data, ex_illegal
   );

   modport slave (
      input  flush, id_valid, id_opcode, id_funct3, id_funct7b5, id_rs1_data,
             id_rs2_data, id_imm, id_pc, id_rd, ex_ready,
`ifdef FWD_EN
             id_rs1, id_rs2, fwd_valid, fwd_rd, fwd_data,
`endif
      output id_ready, ex_valid, alu_in1, alu_in2, alu_funsel, ex_rd,
             ex_is_branch, ex_is_cmp, ex_funct3, ex_rs2_data, ex_illegal
   );
endinterface

`default_nettype wire

// File: rtl/ex_issue_stage.sv
// ============================================================================
// Module : ex_issue_stage
// Brief  : ID/EX register in front of myALU: operand select, funsel decode,
//          valid/ready flow control and flush. Optional macro FWD_EN adds
//          a single-source operand forwarding path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_issue_stage #(
   parameter int XLEN    = 32,
   parameter int REGADDR = 5
) (
   input  logic       clk,
   input  logic       rst,
   ex_issue_if.slave  bus
);
   localparam logic [6:0] c_OP     = 7'b0110011;
   localparam logic [6:0] c_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_BRANCH = 7'b1100011;
   localparam logic [6:0] c_LOAD   = 7'b0000011;
   localparam logic [6:0] c_STORE  = 7'b0100011;
   localparam logic [6:0] c_LUI    = 7'b0110111;
   localparam logic [6:0] c_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_JAL    = 7'b1101111;
   localparam logic [6:0] c_JALR   = 7'b1100111;

   localparam logic [3:0] c_FN_AND  = 4'b0000;
   localparam logic [3:0] c_FN_OR   = 4'b0001;
   localparam logic [3:0] c_FN_ADD  = 4'b0010;
   localparam logic [3:0] c_FN_SUB  = 4'b0110;
   localparam logic [3:0] c_FN_SCMP = 4'b0111;
   localparam logic [3:0] c_FN_UCMP = 4'b1000;
   localparam logic [3:0] c_FN_SLL  = 4'b1001;
   localparam logic [3:0] c_FN_SRL  = 4'b1011;
   localparam logic [3:0] c_FN_XOR  = 4'b1100;

   localparam logic [XLEN-1:0] c_LINK_OFS = XLEN'(4);

   logic [XLEN-1:0]    w_rs1;
   logic [XLEN-1:0]    w_rs2;
   logic [XLEN-1:0]    w_in1;
   logic [XLEN-1:0]    w_in2;
   logic [3:0]         w_fun;
   logic [REGADDR-1:0] w_rd;
   logic               w_br;
   logic               w_cmp;
   logic               w_ill;
   logic               w_load;

`ifdef FWD_EN
   // x0 is never forwarded: its architectural value is always zero.
   assign w_rs1 = (bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.id_rs1))
                  ? bus.fwd_data : bus.id_rs1_data;
   assign w_rs2 = (bus.fwd_valid && (bus.fwd_rd != '0) && (bus.fwd_rd == bus.id_rs2))
                  ? bus.fwd_data : bus.id_rs2_data;
`else
   assign w_rs1 = bus.id_rs1_data;
   assign w_rs2 = bus.id_rs2_data;
`endif

   assign bus.id_ready = !bus.ex_valid || bus.ex_ready;
   assign w_load       = bus.id_valid && bus.id_ready;

   always_comb begin
      w_in1 = w_rs1;
      w_in2 = w_rs2;
      w_fun = c_FN_ADD;
      w_rd  = bus.id_rd;
      w_br  = 1'b0;
      w_cmp = 1'b0;
      w_ill = 1'b0;
      case (bus.id_opcode)
         c_OP, c_OP_IMM: begin
            if (bus.id_opcode == c_OP_IMM) w_in2 = bus.id_imm;
            case (bus.id_funct3)
               3'b000: w_fun = (bus.id_opcode == c_OP && bus.id_funct7b5) ? c_FN_SUB : c_FN_ADD;
               3'b001: w_fun = c_FN_SLL;
               3'b010: begin w_fun = c_FN_SCMP; w_cmp = 1'b1; end
               3'b011: begin w_fun = c_FN_UCMP; w_cmp = 1'b1; end
               3'b100: w_fun = c_FN_XOR;
               // No arithmetic right shift in the ALU, so SRA/SRAI trap as illegal.
               3'b101: begin
                  if (bus.id_funct7b5) begin
                     w_fun = c_FN_AND;
                     w_ill = 1'b1;
                  end else begin
                     w_fun = c_FN_SRL;
                  end
               end
               3'b110: w_fun = c_FN_OR;
               default: w_fun = c_FN_AND;
            endcase
         end
         c_BRANCH: begin
            w_fun = (bus.id_funct3[2:1] == 2'b11) ? c_FN_UCMP : c_FN_SCMP;
            w_br  = 1'b1;
            w_rd  = '0;
         end
         c_LOAD:  w_in2 = bus.id_imm;
         c_STORE: begin w_in2 = bus.id_imm; w_rd = '0; end
         c_LUI:   begin w_in1 = '0; w_in2 = bus.id_imm; end
         c_AUIPC: begin w_in1 = bus.id_pc; w_in2 = bus.id_imm; end
         c_JAL, c_JALR: begin w_in1 = bus.id_pc; w_in2 = c_LINK_OFS; end
         default: begin
            w_in1 = '0;
            w_in2 = '0;
            w_fun = c_FN_AND;
            w_rd  = '0;
            w_ill = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         bus.ex_valid     <= 1'b0;
         bus.alu_in1      <= '0;
         bus.alu_in2      <= '0;
         bus.alu_funsel   <= '0;
         bus.ex_rd        <= '0;
         bus.ex_is_branch <= 1'b0;
         bus.ex_is_cmp    <= 1'b0;
         bus.ex_funct3    <= '0;
         bus.ex_rs2_data  <= '0;
         bus.ex_illegal   <= 1'b0;
      end else if (w_load) begin
         bus.ex_valid     <= 1'b1;
         bus.alu_in1      <= w_in1;
         bus.alu_in2      <= w_in2;
         bus.alu_funsel   <= w_fun;
         bus.ex_rd        <= w_rd;
         bus.ex_is_branch <= w_br;
         bus.ex_is_cmp    <= w_cmp;
         bus.ex_funct3    <= bus.id_funct3;
         bus.ex_rs2_data  <= w_rs2;
         bus.ex_illegal   <= w_ill;
      end else if (bus.ex_ready) begin
         bus.ex_valid     <= 1'b0;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
// ============================================================================
// Module : tb_ex_issue_stage
// Brief  : Directed and randomized checks of ex_issue_stage against a
//          mnemonic-level reference model (FWD_EN adds forwarding checks).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_issue_stage;
   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  fun;
      logic [4:0]  rd;
      logic        br;
      logic        cmp;
      logic        ill;
   } dec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic        m_valid = 1'b0;
   logic        m_clear = 1'b0;
   logic        m_rst   = 1'b0;
   dec_t        m_d     = '0;
   logic [2:0]  m_f3    = '0;
   logic [31:0] m_rs2   = '0;

   ex_issue_if #(.XLEN(32), .REGADDR(5)) bus ();

   ex_issue_stage #(.XLEN(32), .REGADDR(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode: instruction -> mnemonic -> ALU function code.
   function automatic dec_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [4:0] rd);
      dec_t  d;
      string mn;
      d = '{in1: a, in2: b, fun: 4'b0000, rd: rd, br: 1'b0, cmp: 1'b0, ill: 1'b0};
      mn = "ADD";
      case (opc)
         7'h33, 7'h13: begin
            if (opc == 7'h13) d.in2 = imm;
            case (f3)
               3'd0: mn = (opc == 7'h33 && f7) ? "SUB" : "ADD";
               3'd1: mn = "SLL";
               3'd2: mn = "SLT";
               3'd3: mn = "SLTU";
               3'd4: mn = "XOR";
               3'd5: mn = f7 ? "SRA" : "SRL";
               3'd6: mn = "OR";
               default: mn = "AND";
            endcase
            d.cmp = (mn == "SLT" || mn == "SLTU");
         end
         7'h63: begin
            mn   = (f3 == 3'd6 || f3 == 3'd7) ? "SLTU" : "SLT";
            d.br = 1'b1;
            d.rd = 5'd0;
         end
         7'h03: d.in2 = imm;
         7'h23: begin d.in2 = imm; d.rd = 5'd0; end
         7'h37: begin d.in1 = 32'd0; d.in2 = imm; end
         7'h17: begin d.in1 = pc; d.in2 = imm; end
         7'h6F, 7'h67: begin d.in1 = pc; d.in2 = 32'd4; end
         default: begin mn = "ILL"; d.in1 = 32'd0; d.in2 = 32'd0; d.rd = 5'd0; end
      endcase
      case (mn)
         "AND":  d.fun = 4'b0000;
         "OR":   d.fun = 4'b0001;
         "ADD":  d.fun = 4'b0010;
         "SUB":  d.fun = 4'b0110;
         "SLT":  d.fun = 4'b0111;
         "SLTU": d.fun = 4'b1000;
         "SLL":  d.fun = 4'b1001;
         "SRL":  d.fun = 4'b1011;
         "XOR":  d.fun = 4'b1100;
         default: begin d.fun = 4'b0000; d.ill = 1'b1; end
      endcase
      return d;
   endfunction

   task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic rdy, input logic fl);
      bus.id_valid    = v;
      bus.id_opcode   = opc;
      bus.id_funct3   = f3;
      bus.id_funct7b5 = f7;
      bus.id_rs1_data = a;
      bus.id_rs2_data = b;
      bus.id_imm      = imm;
      bus.id_pc       = pc;
      bus.id_rd       = rd;
      bus.ex_ready    = rdy;
      bus.flush       = fl;
`ifdef FWD_EN
      bus.id_rs1    = 5'($urandom);
      bus.id_rs2    = 5'($urandom);
      bus.fwd_valid = 1'b0;
      bus.fwd_rd    = 5'($urandom);
      bus.fwd_data  = $urandom;
`endif
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle();
      dec_t        d;
      logic        rdy;
      logic [31:0] r1;
      logic [31:0] r2;
      #1;
      rdy = !m_valid || bus.ex_ready;
      if (!rst) chk("id_ready_pre", {31'd0, bus.id_ready}, {31'd0, rdy});
      r1 = bus.id_rs1_data;
      r2 = bus.id_rs2_data;
`ifdef FWD_EN
      if (bus.fwd_valid && bus.fwd_rd != 5'd0 && bus.fwd_rd == bus.id_rs1) r1 = bus.fwd_data;
      if (bus.fwd_valid && bus.fwd_rd != 5'd0 && bus.fwd_rd == bus.id_rs2) r2 = bus.fwd_data;
`endif
      d = ref_dec(bus.id_opcode, bus.id_funct3, bus.id_funct7b5, r1, r2,
                  bus.id_imm, bus.id_pc, bus.id_rd);
      m_rst = rst;
      if (rst || bus.flush) begin
         m_valid = 1'b0; m_clear = 1'b1; m_d = '0; m_f3 = '0; m_rs2 = '0;
      end else if (bus.id_valid && rdy) begin
         m_valid = 1'b1; m_clear = 1'b0; m_d = d; m_f3 = bus.id_funct3; m_rs2 = r2;
      end else if (bus.ex_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
      chk("id_ready_post", {31'd0, bus.id_ready}, {31'd0, (!m_valid || bus.ex_ready)});
      if (m_valid || m_clear) begin
         chk("alu_in1", bus.alu_in1, m_d.in1);
         chk("alu_in2", bus.alu_in2, m_d.in2);
         chk("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m_d.rd});
      end
      if (m_valid || m_rst) begin
         chk("alu_funsel", {28'd0, bus.alu_funsel}, {28'd0, m_d.fun});
         chk("ex_is_branch", {31'd0, bus.ex_is_branch}, {31'd0, m_d.br});
         chk("ex_is_cmp", {31'd0, bus.ex_is_cmp}, {31'd0, m_d.cmp});
         chk("ex_illegal", {31'd0, bus.ex_illegal}, {31'd0, m_d.ill});
         chk("ex_funct3", {29'd0, bus.ex_funct3}, {29'd0, m_f3});
         chk("ex_rs2_data", bus.ex_rs2_data, m_rs2);
      end
      @(negedge clk);
   endtask

   logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};

   initial begin
      logic [6:0] opc;
      drive(1'b0, 7'h33, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      cycle();
      chk("reset_id_ready", {31'd0, bus.id_ready}, 32'd1);
      rst = 1'b0;

      // 1: ADD x3 = 5 + 7
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0);
      cycle();
      chk("t1_in1", bus.alu_in1, 32'd5);
      chk("t1_in2", bus.alu_in2, 32'd7);
      chk("t1_fun", {28'd0, bus.alu_funsel}, 32'b0010);
      chk("t1_rd", {27'd0, bus.ex_rd}, 32'd3);

      // 2: stall three cycles with a SUB waiting, then release
      drive(1'b1, 7'h33, 3'd0, 1'b1, 32'd20, 32'd8, 32'd0, 32'd0, 5'd9, 1'b0, 1'b0);
      repeat (3) begin
         cycle();
         chk("t2_hold_in1", bus.alu_in1, 32'd5);
      end
      bus.ex_ready = 1'b1;
      cycle();
      chk("t2_sub_fun", {28'd0, bus.alu_funsel}, 32'b0110);
      chk("t2_sub_rd", {27'd0, bus.ex_rd}, 32'd9);

      // 3: BLTU
      drive(1'b1, 7'h63, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 5'd7, 1'b1, 1'b0);
      cycle();
      chk("t3_fun", {28'd0, bus.alu_funsel}, 32'b1000);
      chk("t3_br", {31'd0, bus.ex_is_branch}, 32'd1);
      chk("t3_rd", {27'd0, bus.ex_rd}, 32'd0);

      // 4: flush while stalled with a new offer
      drive(1'b1, 7'h13, 3'd4, 1'b0, 32'd1, 32'd2, 32'd3, 32'd0, 5'd4, 1'b0, 1'b1);
      cycle();
      chk("t4_in1", bus.alu_in1, 32'd0);
      chk("t4_in2", bus.alu_in2, 32'd0);

      // 5: SRAI illegal, then AUIPC
      drive(1'b1, 7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd3, 32'd0, 5'd5, 1'b1, 1'b0);
      cycle();
      chk("t5_ill", {31'd0, bus.ex_illegal}, 32'd1);
      chk("t5_fun", {28'd0, bus.alu_funsel}, 32'b0000);
      drive(1'b1, 7'h17, 3'd0, 1'b0, 32'd77, 32'd0, 32'h2000, 32'h100, 5'd6, 1'b1, 1'b0);
      cycle();
      chk("t5_auipc_in1", bus.alu_in1, 32'h100);
      chk("t5_auipc_in2", bus.alu_in2, 32'h2000);

      // 6: reset in the middle of a stall
      drive(1'b1, 7'h33, 3'd7, 1'b0, 32'hF0, 32'h3C, 32'd0, 32'd0, 5'd8, 1'b0, 1'b0);
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_valid", {31'd0, bus.ex_valid}, 32'd0);
      chk("t6_in1", bus.alu_in1, 32'd0);
      chk("t6_ready", {31'd0, bus.id_ready}, 32'd1);

`ifdef FWD_EN
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0);
      bus.id_rs1    = 5'd4;
      bus.id_rs2    = 5'd5;
      bus.fwd_valid = 1'b1;
      bus.fwd_rd    = 5'd4;
      bus.fwd_data  = 32'd9;
      cycle();
      chk("fwd_in1", bus.alu_in1, 32'd9);
      chk("fwd_in2", bus.alu_in2, 32'd2);
`endif

      for (int i = 0; i < 400; i++) begin
         opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 8)];
         drive($urandom_range(0, 3) != 0, opc, 3'($urandom), 1'($urandom), $urandom, $urandom,
               $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
`ifdef FWD_EN
         bus.fwd_valid = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 1) == 1) bus.fwd_rd = bus.id_rs1;
`endif
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
